// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, start/done handshake and retired-instruction counter
module pc_sequencer #(
    parameter int              PC_W       = 10,
    parameter int              CNT_W      = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic             taken,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                pc_d    = START_ADDR;
                cnt_d   = '0;
            end
        end else if (!stall) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            if (halt)
                state_d = DONE;
            else
                pc_d = (jump_en || (branch_en && taken)) ? target : pc_q + PC_W'(1);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end
    assign prog_ctr  = pc_q;
    assign instr_cnt = cnt_q;
    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        start = 0, stall = 0, halt = 0, jump_en = 0, branch_en = 0, taken = 0;
    logic [9:0]  target = '0;
    logic [9:0]  prog_ctr, prog_ctr4;
    logic        running, done, running4, done4;
    logic [15:0] instr_cnt;
    logic [3:0]  instr_cnt4;

    int n_vec = 0, n_err = 0;
    int m_pc = 0, m_cnt = 0, m_cnt4 = 0;
    bit m_run = 0, m_done = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt(halt),
        .jump_en(jump_en), .branch_en(branch_en), .taken(taken), .target(target),
        .prog_ctr(prog_ctr), .running(running), .done(done), .instr_cnt(instr_cnt)
    );

    pc_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt(halt),
        .jump_en(jump_en), .branch_en(branch_en), .taken(taken), .target(target),
        .prog_ctr(prog_ctr4), .running(running4), .done(done4), .instr_cnt(instr_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pc"},      32'(prog_ctr),   32'(m_pc));
        check({tag, "_run"},     32'(running),    32'(m_run));
        check({tag, "_done"},    32'(done),       32'(m_done));
        check({tag, "_cnt"},     32'(instr_cnt),  32'(m_cnt));
        check({tag, "_pc4"},     32'(prog_ctr4),  32'(m_pc));
        check({tag, "_run4"},    32'(running4),   32'(m_run));
        check({tag, "_done4"},   32'(done4),      32'(m_done));
        check({tag, "_cnt4"},    32'(instr_cnt4), 32'(m_cnt4));
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_run = 0; m_done = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic cyc(input string tag, input bit st, input bit stl, input bit h,
                       input bit j, input bit b, input bit tk, input int tgt);
        start = st; stall = stl; halt = h; jump_en = j; branch_en = b; taken = tk;
        target = 10'(tgt);
        @(posedge clk);
        if (!m_run) begin
            if (st) begin
                m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
            end
        end else if (!stl) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
            m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            if (h) begin
                m_run = 0; m_done = 1;
            end else if (j || (b && tk)) m_pc = tgt % 1024;
            else m_pc = (m_pc + 1) % 1024;
        end
        #1 check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 0;
        model_reset();
        #1 check_all(tag);
        @(negedge clk) reset_n = 1;
    endtask

    initial begin
        #1 check_all("rst");
        @(negedge clk) reset_n = 1;
        cyc("idle", 0, 0, 1, 1, 1, 1, 7);
        // basic sequential fetch
        cyc("t1_start", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("t1_seq", 0, 0, 0, 0, 0, 0, 0);
        check("t1_pc5", 32'(prog_ctr), 5);
        check("t1_cnt5", 32'(instr_cnt), 5);
        cyc("t1_start_in_run", 1, 0, 0, 0, 0, 0, 0);
        // branch taken / not taken from pc 3
        cyc("t2_j3", 0, 0, 0, 1, 0, 0, 3);
        cyc("t2_bt", 0, 0, 0, 0, 1, 1, 'h40);
        check("t2_pc40", 32'(prog_ctr), 'h40);
        cyc("t2_j3b", 0, 0, 0, 1, 0, 0, 3);
        cyc("t2_bnt", 0, 0, 0, 0, 1, 0, 'h40);
        check("t2_pc4", 32'(prog_ctr), 4);
        cyc("t2_tk_only", 0, 0, 0, 0, 0, 1, 'h40);
        // jump priority and address wrap
        cyc("t3_jb", 0, 0, 0, 1, 1, 0, 'h1FF);
        check("t3_pc1ff", 32'(prog_ctr), 'h1FF);
        cyc("t3_j3fe", 0, 0, 0, 1, 0, 0, 'h3FE);
        cyc("t3_3ff", 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_wrap", 0, 0, 0, 0, 0, 0, 0);
        check("t3_pc0", 32'(prog_ctr), 0);
        // stalled halt, then halt retires
        for (int i = 0; i < 3; i++) cyc("t4_stall", 0, 1, 1, 1, 1, 1, 'h55);
        cyc("t4_halt", 0, 0, 1, 0, 0, 0, 0);
        check("t4_done", 32'(done), 1);
        cyc("t4_hold", 0, 0, 0, 1, 0, 0, 9);
        // restart from DONE, then async reset mid-run
        cyc("t5_restart", 1, 0, 0, 0, 0, 0, 0);
        check("t5_run", 32'(running), 1);
        for (int i = 0; i < 3; i++) cyc("t5_seq", 0, 0, 0, 0, 0, 0, 0);
        async_reset("t5_areset");
        // counter saturation on the 4-bit instance
        cyc("t6_start", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc("t6_run", 0, 0, 0, 0, 0, 0, 0);
        check("t6_sat15", 32'(instr_cnt4), 15);
        check("t6_cnt20", 32'(instr_cnt), 20);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset("rnd_areset");
            else cyc("rnd", $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 1023)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and fetch-sequencing stage of the 8-bit core. It sits directly downstream of the ALU and consumes its `taken` flag, together with decoder control, to select the next instruction address. It drives `prog_ctr` to instruction memory. It also owns the start/done program handshake and a retired-instruction counter.

Parameters:
PC_W, 10, width of program counter / instruction-memory address
CNT_W, 16, width of retired-instruction counter
START_ADDR, 0, address loaded on reset and on every start

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin program execution (sampled in IDLE or DONE only)
stall  input  1  hold current instruction; no PC advance, no count
halt  input  1  decoder: current instruction is halt
jump_en  input  1  decoder: unconditional jump
branch_en  input  1  decoder: conditional branch (beq/pos class)
taken  input  1  ALU branch condition result
target  input  PC_W  absolute branch/jump target from decoder target LUT
prog_ctr  output  PC_W  current instruction address
running  output  1  high while in RUN
done  output  1  program finished; held until next start
instr_cnt  output  CNT_W  instructions retired since last start

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (reset_n low, asynchronous, takes effect immediately, including mid-run):
  - state=IDLE, prog_ctr=START_ADDR, running=0, done=0, instr_cnt=0.
  - Release is synchronous to clk.
- IDLE:
  - start=1: next cycle state=RUN, prog_ctr=START_ADDR, instr_cnt=0, done=0.
  - All other inputs are ignored.
- RUN, stall=1: prog_ctr, instr_cnt and state hold. halt, jump_en and branch_en are ignored that cycle.
- RUN, stall=0: the instruction at prog_ctr retires.
  - instr_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - Next-PC priority, highest first:
    1. halt=1: state->DONE; prog_ctr holds (points at the halt instruction); done=1 and running=0 from the next cycle.
    2. jump_en=1: prog_ctr<=target.
    3. branch_en=1 and taken=1: prog_ctr<=target.
    4. Otherwise: prog_ctr<=prog_ctr+1, modulo 2^PC_W (wraps from max address to 0 silently).
  - taken with branch_en=0 has no effect.
  - jump_en and branch_en both high: jump wins (same target).
- start while in RUN is ignored.
- DONE:
  - prog_ctr, instr_cnt and done=1 hold.
  - start=1: next cycle is identical to the IDLE start (done drops the same cycle running rises).
- Latency: one cycle from a control decision to the new prog_ctr. No combinational path from any input to any output; all outputs are registered.
- running is high exactly when state==RUN. done is high exactly when state==DONE.

Test Plan:
1. Reset, start pulse, stall=0, no control for 5 cycles -> prog_ctr 0,1,2,3,4,5; instr_cnt=5; running=1; done=0.
2. At prog_ctr=3: branch_en=1, taken=1, target=0x40 -> next prog_ctr=0x40. Repeat with taken=0 -> next prog_ctr=4.
3. jump_en=1 and branch_en=1, taken=0, target=0x1FF -> prog_ctr=0x1FF. Then free-run 0x3FF -> 0x000 wrap (PC_W=10).
4. stall=1 for 3 cycles with halt=1 asserted -> prog_ctr/instr_cnt unchanged, state stays RUN. Drop stall with halt=1 -> DONE, done=1, prog_ctr holds, instr_cnt +1.
5. In DONE, assert start -> prog_ctr=0, instr_cnt=0, done=0, running=1 next cycle. Pulse reset_n low mid-run between clock edges -> outputs reset immediately without a clock edge.
6. CNT_W=4: run 20 instructions -> instr_cnt saturates at 15.
